// File: rtl/comm_fx2_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : comm_fx2_pkg
//  Description : Shared types and constants for the FX2 slave-FIFO protocol
//                engine: engine state encoding, command direction bit,
//                FIFO-select codes and the length-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package comm_fx2_pkg;

   // Engine states. The encoding is fixed so that debug captures are stable.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GET_LEN = 3'd1,
      H2F     = 3'd2,
      TURN    = 3'd3,
      F2H     = 3'd4,
      PKTEND  = 3'd5
   } state_e;

   // Bit of the command byte that selects the transfer direction (1 = read).
   localparam int CMD_DIR_BIT = 7;

   // FX2 FIFO select codes.
   localparam logic FIFO_OUT = 1'b0;   // EP2, host -> FPGA
   localparam logic FIFO_IN  = 1'b1;   // EP6, FPGA -> host

   // Width of the index that walks the length bytes. A single length byte
   // still needs a one-bit index so the port/register never collapses to 0.
   function automatic int len_idx_width(input int len_bytes);
      return (len_bytes <= 1) ? 1 : $clog2(len_bytes);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fx2_xfer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_xfer_counter
//  Description : Transfer bookkeeping for the FX2 engine. Assembles the
//                big-endian length field, counts the remaining bytes down,
//                tracks the position inside the current IN packet and
//                raises the last-byte / short-packet flags.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i        in   clock
//    rst_ni       in   asynchronous active-low reset
//    start_i      in   command accepted: clear length count and byte index
//    len_shift_i  in   shift len_byte_i into the length (MSB first)
//    len_byte_i   in   length byte from the FX2 bus
//    dec_i        in   one data byte moved: decrement the remaining count
//    pkt_clr_i    in   clear the IN packet byte position
//    pkt_inc_i    in   one IN byte written: advance the packet position
//    len_last_o   out  the length byte being read now is the final one
//    len_zero_o   out  the length including the current byte is zero
//    cnt_last_o   out  exactly one data byte remains
//    pkt_short_o  out  writing one more IN byte leaves a partial packet
// ============================================================================
module fx2_xfer_counter
   import comm_fx2_pkg::*;
#(
   parameter int LEN_BYTES = 4,
   parameter int PKT_SIZE  = 512
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       len_shift_i,
   input  logic [7:0] len_byte_i,
   input  logic       dec_i,
   input  logic       pkt_clr_i,
   input  logic       pkt_inc_i,
   output logic       len_last_o,
   output logic       len_zero_o,
   output logic       cnt_last_o,
   output logic       pkt_short_o
);

   localparam int CNT_W  = 8 * LEN_BYTES;
   localparam int LIDX_W = len_idx_width(LEN_BYTES);
   localparam int PKT_W  = $clog2(PKT_SIZE);

   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [LIDX_W-1:0] lidx_q, lidx_d;
   logic [PKT_W-1:0]  pkt_q,  pkt_d;
   logic [CNT_W-1:0]  w_shifted;

   // Length value with the current bus byte appended as the new LSB.
   generate
      if (LEN_BYTES > 1) begin : g_shift_multi
         assign w_shifted = {cnt_q[CNT_W-9:0], len_byte_i};
      end else begin : g_shift_single
         assign w_shifted = len_byte_i;
      end
   endgenerate

   always_comb begin
      cnt_d  = cnt_q;
      lidx_d = lidx_q;
      pkt_d  = pkt_q;

      if (start_i) begin
         cnt_d  = '0;
         lidx_d = '0;
      end else if (len_shift_i) begin
         cnt_d  = w_shifted;
         lidx_d = lidx_q + LIDX_W'(1);
      end else if (dec_i) begin
         cnt_d  = cnt_q - CNT_W'(1);
      end

      // PKT_SIZE is a power of two, so the natural wrap of the register is
      // exactly the modulo-PKT_SIZE packet position.
      if (pkt_clr_i) begin
         pkt_d = '0;
      end else if (pkt_inc_i) begin
         pkt_d = pkt_q + PKT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         lidx_q <= '0;
         pkt_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         lidx_q <= lidx_d;
         pkt_q  <= pkt_d;
      end
   end

   assign len_last_o  = (lidx_q == LIDX_W'(LEN_BYTES - 1));
   assign len_zero_o  = (w_shifted == '0);
   assign cnt_last_o  = (cnt_q == CNT_W'(1));
   // After the increment the position is non-zero unless the packet was
   // one byte short of full, i.e. the position is currently all ones.
   assign pkt_short_o = ~(&pkt_q);

endmodule
`default_nettype wire

// File: rtl/comm_fpga_fx2_mc.sv
`default_nettype none
// ============================================================================
//  Module      : comm_fpga_fx2_mc
//  Description : FX2 slave-FIFO protocol engine for the FPGALink host link.
//                Parses a command byte and a big-endian length, then streams
//                EP2 data onto the h2f channel or f2h data into EP6, with an
//                explicit bus turnaround and exact short-packet commit.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_in          in   clock, rising edge
//    reset_in        in   asynchronous active-low reset
//    fx2FifoSel_out  out  0 = EP2 (host->FPGA), 1 = EP6 (FPGA->host)
//    fx2Data_in      in   FX2 data bus input
//    fx2Data_out     out  FX2 data bus output
//    fx2Data_sel     out  1 = FPGA drives the FX2 bus
//    fx2Read_out     out  SLRD, active-low
//    fx2GotData_in   in   EP2 not empty
//    fx2Write_out    out  SLWR, active-low
//    fx2GotRoom_in   in   EP6 not full
//    fx2PktEnd_out   out  PKTEND, active-low single-cycle pulse
//    chanAddr_out    out  channel of the current transfer
//    h2fData_out     out  host->FPGA data
//    h2fValid_out    out  host->FPGA valid
//    h2fReady_in     in   host->FPGA ready
//    f2hData_in      in   FPGA->host data
//    f2hValid_in     in   FPGA->host valid
//    f2hReady_out    out  FPGA->host ready
//    xferActive_out  out  transfer in progress
//    xferDir_out     out  latched direction, 1 = read
// ============================================================================
module comm_fpga_fx2_mc
   import comm_fx2_pkg::*;
#(
   parameter int CHAN_WIDTH = 7,
   parameter int LEN_BYTES  = 4,
   parameter int PKT_SIZE   = 512
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   output logic                  fx2FifoSel_out,
   input  logic [7:0]            fx2Data_in,
   output logic [7:0]            fx2Data_out,
   output logic                  fx2Data_sel,
   output logic                  fx2Read_out,
   input  logic                  fx2GotData_in,
   output logic                  fx2Write_out,
   input  logic                  fx2GotRoom_in,
   output logic                  fx2PktEnd_out,
   output logic [CHAN_WIDTH-1:0] chanAddr_out,
   output logic [7:0]            h2fData_out,
   output logic                  h2fValid_out,
   input  logic                  h2fReady_in,
   input  logic [7:0]            f2hData_in,
   input  logic                  f2hValid_in,
   output logic                  f2hReady_out
   ,
   output logic                  xferActive_out,
   output logic                  xferDir_out
);

   state_e                state_q, state_d;
   logic [CHAN_WIDTH-1:0] chan_q,  chan_d;
   logic                  dir_q,   dir_d;
   logic [1:0]            run_q;

   logic w_start, w_len_shift, w_dec, w_pkt_clr, w_pkt_inc;
   logic w_len_last, w_len_zero, w_cnt_last, w_pkt_short;
   logic w_cmd_rd, w_h2f_hs, w_f2h_hs;

   // Reset is asserted asynchronously everywhere; its release reaches the
   // engine through this two-stage enable. Until it is set no command byte
   // is read, so no state or counter register can change on the edge where
   // reset_in is released.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         run_q <= '0;
      end else begin
         run_q <= {run_q[0], 1'b1};
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= IDLE;
         chan_q  <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         dir_q   <= dir_d;
      end
   end

   assign w_cmd_rd = run_q[1] & fx2GotData_in;
   assign w_h2f_hs = fx2GotData_in & h2fReady_in;
   assign w_f2h_hs = f2hValid_in & fx2GotRoom_in;

   always_comb begin
      state_d        = state_q;
      chan_d         = chan_q;
      dir_d          = dir_q;
      fx2FifoSel_out = FIFO_OUT;
      fx2Data_out    = 8'h00;
      fx2Data_sel    = 1'b0;
      fx2Read_out    = 1'b1;
      fx2Write_out   = 1'b1;
      fx2PktEnd_out  = 1'b1;
      h2fData_out    = 8'h00;
      h2fValid_out   = 1'b0;
      f2hReady_out   = 1'b0;
      w_start        = 1'b0;
      w_len_shift    = 1'b0;
      w_dec          = 1'b0;
      w_pkt_clr      = 1'b0;
      w_pkt_inc      = 1'b0;

      case (state_q)
         IDLE: begin
            fx2Read_out = ~w_cmd_rd;
            if (w_cmd_rd) begin
               chan_d  = fx2Data_in[CHAN_WIDTH-1:0];
               dir_d   = fx2Data_in[CMD_DIR_BIT];
               w_start = 1'b1;
               state_d = GET_LEN;
            end
         end

         GET_LEN: begin
            fx2Read_out = ~fx2GotData_in;
            if (fx2GotData_in) begin
               w_len_shift = 1'b1;
               if (w_len_last) begin
                  if (w_len_zero) begin
                     state_d = IDLE;
                  end else if (dir_q) begin
                     // Packet position restarts with every read transfer.
                     w_pkt_clr = 1'b1;
                     state_d   = TURN;
                  end else begin
                     state_d = H2F;
                  end
               end
            end
         end

         H2F: begin
            h2fData_out  = fx2Data_in;
            h2fValid_out = fx2GotData_in;
            fx2Read_out  = ~w_h2f_hs;
            if (w_h2f_hs) begin
               w_dec = 1'b1;
               if (w_cnt_last) begin
                  state_d = IDLE;
               end
            end
         end

         // One idle cycle on EP6 so the FX2 flags settle after the switch.
         TURN: begin
            fx2FifoSel_out = FIFO_IN;
            state_d        = F2H;
         end

         F2H: begin
            fx2FifoSel_out = FIFO_IN;
            fx2Data_sel    = 1'b1;
            fx2Data_out    = f2hData_in;
            f2hReady_out   = fx2GotRoom_in;
            fx2Write_out   = ~w_f2h_hs;
            if (w_f2h_hs) begin
               w_dec     = 1'b1;
               w_pkt_inc = 1'b1;
               if (w_cnt_last) begin
                  // A full final packet commits itself; a partial one
                  // needs an explicit PKTEND.
                  state_d = w_pkt_short ? PKTEND : IDLE;
               end
            end
         end

         PKTEND: begin
            fx2FifoSel_out = FIFO_IN;
            fx2PktEnd_out  = 1'b0;
            state_d        = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   fx2_xfer_counter #(
      .LEN_BYTES (LEN_BYTES),
      .PKT_SIZE  (PKT_SIZE)
   ) u_counter (
      .clk_i       (clk_in),
      .rst_ni      (reset_in),
      .start_i     (w_start),
      .len_shift_i (w_len_shift),
      .len_byte_i  (fx2Data_in),
      .dec_i       (w_dec),
      .pkt_clr_i   (w_pkt_clr),
      .pkt_inc_i   (w_pkt_inc),
      .len_last_o  (w_len_last),
      .len_zero_o  (w_len_zero),
      .cnt_last_o  (w_cnt_last),
      .pkt_short_o (w_pkt_short)
   );

   assign chanAddr_out   = chan_q;
   assign xferDir_out    = dir_q;
   assign xferActive_out = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_comm_fpga_fx2_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comm_fpga_fx2_mc
//  Description : Scoreboard bench for comm_fpga_fx2_mc. Two instances
//                (default widths, and LEN_BYTES=2 / CHAN_WIDTH=3 /
//                PKT_SIZE=64) are exercised one at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comm_fpga_fx2_mc;

   localparam int NI  = 2;
   localparam int CW0 = 7, LB0 = 4, PS0 = 512;
   localparam int CW1 = 3, LB1 = 2, PS1 = 64;

   localparam int K_H2F = 0, K_EP6 = 1, K_PKT = 2, K_TURN = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic [6:0] chan;
      logic       dir;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn       [NI];
   logic [7:0] fx2DataIn  [NI];
   logic       gotData    [NI];
   logic       gotRoom    [NI];
   logic       h2fReady   [NI];
   logic [7:0] f2hData    [NI];
   logic       f2hValid   [NI];
   logic       fifoSel    [NI];
   logic [7:0] fx2DataOut [NI];
   logic       dataSel    [NI];
   logic       rdN        [NI];
   logic       wrN        [NI];
   logic       pktEndN    [NI];
   logic [7:0] h2fDataOut [NI];
   logic       h2fValid   [NI];
   logic       f2hReady   [NI];
   logic       active     [NI];
   logic       dir        [NI];
   logic [CW0-1:0] chan0;
   logic [CW1-1:0] chan1;

   comm_fpga_fx2_mc #(.CHAN_WIDTH(CW0), .LEN_BYTES(LB0), .PKT_SIZE(PS0)) u_dut0 (
      .clk_in(clk), .reset_in(rstn[0]), .fx2FifoSel_out(fifoSel[0]),
      .fx2Data_in(fx2DataIn[0]), .fx2Data_out(fx2DataOut[0]), .fx2Data_sel(dataSel[0]),
      .fx2Read_out(rdN[0]), .fx2GotData_in(gotData[0]), .fx2Write_out(wrN[0]),
      .fx2GotRoom_in(gotRoom[0]), .fx2PktEnd_out(pktEndN[0]), .chanAddr_out(chan0),
      .h2fData_out(h2fDataOut[0]), .h2fValid_out(h2fValid[0]), .h2fReady_in(h2fReady[0]),
      .f2hData_in(f2hData[0]), .f2hValid_in(f2hValid[0]), .f2hReady_out(f2hReady[0]),
      .xferActive_out(active[0]), .xferDir_out(dir[0]));

   comm_fpga_fx2_mc #(.CHAN_WIDTH(CW1), .LEN_BYTES(LB1), .PKT_SIZE(PS1)) u_dut1 (
      .clk_in(clk), .reset_in(rstn[1]), .fx2FifoSel_out(fifoSel[1]),
      .fx2Data_in(fx2DataIn[1]), .fx2Data_out(fx2DataOut[1]), .fx2Data_sel(dataSel[1]),
      .fx2Read_out(rdN[1]), .fx2GotData_in(gotData[1]), .fx2Write_out(wrN[1]),
      .fx2GotRoom_in(gotRoom[1]), .fx2PktEnd_out(pktEndN[1]), .chanAddr_out(chan1),
      .h2fData_out(h2fDataOut[1]), .h2fValid_out(h2fValid[1]), .h2fReady_in(h2fReady[1]),
      .f2hData_in(f2hData[1]), .f2hValid_in(f2hValid[1]), .f2hReady_out(f2hReady[1]),
      .xferActive_out(active[1]), .xferDir_out(dir[1]));

   int         cur = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   ev_t        expq [$];
   logic [7:0] ep2q [$];
   logic [7:0] f2hq [$];
   int         h2f_mode = 0;
   int         room_block = 0;
   int         ep6_seen = 0;
   int         cyc = 0;
   int         last_ep6_cyc = -10;

   function automatic int lenb();
      return (cur == 0) ? LB0 : LB1;
   endfunction

   function automatic int pkts();
      return (cur == 0) ? PS0 : PS1;
   endfunction

   function automatic logic [6:0] chan_mask();
      return (cur == 0) ? 7'h7F : 7'h07;
   endfunction

   function automatic logic [6:0] chan_of();
      return (cur == 0) ? chan0 : {4'b0, chan1};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (inst %0d, t=%0t)", name, act, exp, cur, $time);
      end
   endtask

   // ---------------- FX2 endpoints and channel source/sink model -----------
   task automatic drive_inputs();
      for (int i = 0; i < NI; i++) begin
         if (i == cur) begin
            gotData[i]   = (ep2q.size() > 0) && ($urandom_range(0, 3) != 0);
            fx2DataIn[i] = (ep2q.size() > 0) ? ep2q[0] : 8'($urandom);
            case (h2f_mode)
               1:       h2fReady[i] = 1'b1;
               2:       h2fReady[i] = ~h2fReady[i];
               default: h2fReady[i] = ($urandom_range(0, 3) != 0);
            endcase
            f2hValid[i] = (f2hq.size() > 0) && ($urandom_range(0, 3) != 0);
            f2hData[i]  = (f2hq.size() > 0) ? f2hq[0] : 8'($urandom);
            gotRoom[i]  = (room_block == 0) && ($urandom_range(0, 3) != 0);
         end else begin
            gotData[i]   = 1'b0;
            fx2DataIn[i] = 8'h00;
            h2fReady[i]  = 1'b0;
            f2hValid[i]  = 1'b0;
            f2hData[i]   = 8'h00;
            gotRoom[i]   = 1'b0;
         end
      end
   endtask

   initial begin : p_model
      bit hs_rd, hs_f2h;
      for (int i = 0; i < NI; i++) begin
         gotData[i] = 1'b0; fx2DataIn[i] = 8'h00; h2fReady[i] = 1'b0;
         f2hValid[i] = 1'b0; f2hData[i] = 8'h00; gotRoom[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         hs_rd  = (rstn[cur] === 1'b1) && !rdN[cur] && gotData[cur];
         hs_f2h = (rstn[cur] === 1'b1) && f2hValid[cur] && f2hReady[cur];
         @(posedge clk);
         #1;
         if (hs_rd && ep2q.size() > 0)  void'(ep2q.pop_front());
         if (hs_f2h && f2hq.size() > 0) void'(f2hq.pop_front());
         if (room_block > 0) room_block--;
         drive_inputs();
      end
   end

   // ---------------- Monitor: observe events, pop and compare ---------------
   always @(negedge clk) begin : p_mon
      int         kind;
      logic [7:0] d;
      ev_t        e;
      cyc++;
      if (rstn[cur] === 1'b1) begin
         kind = -1;
         d    = 8'h00;
         if (h2fValid[cur] && h2fReady[cur]) begin
            kind = K_H2F; d = h2fDataOut[cur];
         end else if (!wrN[cur]) begin
            kind = K_EP6; d = fx2DataOut[cur];
         end else if (!pktEndN[cur]) begin
            kind = K_PKT;
         end else if (fifoSel[cur] && !dataSel[cur] && active[cur]) begin
            kind = K_TURN;
         end
         if (kind >= 0) begin
            if (expq.size() == 0) begin
               check("unexpected_event_kind", 32'(kind), 32'd99);
            end else begin
               e = expq.pop_front();
               check("event_kind", 32'(kind), 32'(e.kind));
               check("event_chan", 32'(chan_of()), 32'(e.chan));
               check("event_dir", 32'(dir[cur]), 32'(e.dir));
               if (kind == K_H2F || kind == K_EP6)
                  check("event_data", 32'(d), 32'(e.data));
               if (kind == K_EP6) begin
                  check("ep6_bus_drive", 32'({fifoSel[cur], dataSel[cur]}), 32'd3);
                  ep6_seen++;
                  last_ep6_cyc = cyc;
               end
               if (kind == K_H2F) begin
                  check("h2f_fifosel_slrd", 32'({fifoSel[cur], rdN[cur]}), 32'd0);
               end
               if (kind == K_PKT)
                  check("pktend_after_last", 32'(cyc - last_ep6_cyc), 32'd1);
            end
         end
         if (!gotRoom[cur])
            check("f2h_ready_without_room", 32'(f2hReady[cur]), 32'd0);
      end
   end

   // ---------------- Stimulus ----------------------------------------------
   task automatic flush();
      expq.delete();
      ep2q.delete();
      f2hq.delete();
      room_block = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         done = (expq.size() == 0) && (ep2q.size() == 0) && (f2hq.size() == 0) && !active[cur];
      end
      check({name, "_completed"}, 32'(done), 32'd1);
      if (!done) flush();
      check({name, "_idle_fifosel"}, 32'(fifoSel[cur]), 32'd0);
   endtask

   // Reference model: command byte, big-endian length, then the expected
   // stream of events derived from the transfer rules.
   task automatic issue(input logic [7:0] cmd, input int len, input bit pat);
      logic [6:0] ch;
      logic       dr;
      logic [7:0] b;
      ch = cmd[6:0] & chan_mask();
      dr = cmd[7];
      ep6_seen = 0;
      ep2q.push_back(cmd);
      for (int k = lenb() - 1; k >= 0; k--) ep2q.push_back(8'(len >> (8 * k)));
      if (len > 0 && !dr) begin
         for (int i = 0; i < len; i++) begin
            b = pat ? 8'(8'hAA + 17 * i) : 8'($urandom);
            ep2q.push_back(b);
            expq.push_back('{K_H2F, b, ch, dr});
         end
      end
      if (len > 0 && dr) begin
         expq.push_back('{K_TURN, 8'h00, ch, dr});
         for (int i = 0; i < len; i++) begin
            b = pat ? 8'(i + 1) : 8'($urandom);
            f2hq.push_back(b);
            expq.push_back('{K_EP6, b, ch, dr});
         end
         if ((len % pkts()) != 0) expq.push_back('{K_PKT, 8'h00, ch, dr});
      end
   endtask

   task automatic wait_ep6(input string name, input int count);
      int n = 0;
      while (ep6_seen < count && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_reached_byte"}, 32'(ep6_seen >= count), 32'd1);
   endtask

   task automatic xfer(input string name, input logic [7:0] cmd, input int len,
                       input bit pat, input int hmode, input int block_at);
      h2f_mode = hmode;
      issue(cmd, len, pat);
      if (block_at > 0) begin
         wait_ep6(name, block_at);
         room_block = 10;
      end
      wait_idle(name, len * 12 + 300);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_fifosel"},  32'(fifoSel[cur]),  32'd0);
      check({tag, "_datasel"},  32'(dataSel[cur]),  32'd0);
      check({tag, "_slrd"},     32'(rdN[cur]),      32'd1);
      check({tag, "_slwr"},     32'(wrN[cur]),      32'd1);
      check({tag, "_pktend"},   32'(pktEndN[cur]),  32'd1);
      check({tag, "_h2fvalid"}, 32'(h2fValid[cur]), 32'd0);
      check({tag, "_f2hready"}, 32'(f2hReady[cur]), 32'd0);
      check({tag, "_chan"},     32'(chan_of()),     32'd0);
      check({tag, "_active"},   32'(active[cur]),   32'd0);
      check({tag, "_dir"},      32'(dir[cur]),      32'd0);
   endtask

   task automatic reset_mid_read(input logic [7:0] cmd);
      h2f_mode = 0;
      issue(cmd, 5, 1'b1);
      wait_ep6("rst_mid", 2);
      #2;
      rstn[cur] = 1'b0;
      #1;
      check_reset_vals("rst_async");
      flush();
      repeat (3) @(negedge clk);
      check_reset_vals("rst_held");
      #2;
      rstn[cur] = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin : p_main
      for (int i = 0; i < NI; i++) rstn[i] = 1'b0;
      #2;
      for (int i = 0; i < NI; i++) begin
         cur = i;
         check_reset_vals("por");
      end
      cur = 0;
      repeat (3) @(negedge clk);
      #2;
      for (int i = 0; i < NI; i++) rstn[i] = 1'b1;

      for (int inst = 0; inst < NI; inst++) begin
         cur = inst;
         repeat (4) @(negedge clk);
         xfer("wr_chan5_len3",  8'h05, 3, 1'b1, 1, 0);
         xfer("rd_chan12_len5", 8'h92, 5, 1'b1, 0, 0);
         xfer("rd_full_pkt",    8'h81, pkts(), 1'b0, 0, 0);
         xfer("rd_full_pkt_p1", 8'h83, pkts() + 1, 1'b0, 0, 0);
         xfer("wr_zero_len",    8'h03, 0, 1'b0, 0, 0);
         xfer("rd_zero_len",    8'h84, 0, 1'b0, 0, 0);
         xfer("wr_toggle_rdy",  8'h11, 20, 1'b0, 2, 0);
         xfer("rd_room_drop",   8'hA6, 40, 1'b0, 0, 3);
         for (int r = 0; r < 6; r++) begin
            xfer("rand_xfer", 8'($urandom), $urandom_range(0, 150), 1'b0, 0, 0);
         end
         reset_mid_read(8'h92);
         xfer("post_rst_wr", 8'h07, 4, 1'b0, 0, 0);
         xfer("post_rst_rd", 8'h85, 6, 1'b0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : p_watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/comm_fpga_fx2_mc.md
Name: comm_fpga_fx2_mc

Overview:
Parametrised next-generation FX2 slave-FIFO protocol engine for the FPGALink host link.
- Parses host command streams: command byte, then an N-byte big-endian length.
- Moves write data from the FX2 OUT endpoint (EP2) onto the h2f channel stream, and read data from the f2h stream into the FX2 IN endpoint (EP6).
- Over the fixed-width engine it adds: configurable channel-address and length widths, configurable endpoint packet size with exact short-packet commit, an explicit bus turnaround state, zero-length handling, and transfer status outputs.

Parameters:
- CHAN_WIDTH, 7, channel address bits taken from cmd[CHAN_WIDTH-1:0]; legal range 1..7.
- LEN_BYTES, 4, length field bytes, big-endian; legal range 1..4.
- PKT_SIZE, 512, FX2 IN packet size in bytes; must be a power of two, 64..1024.

Ports:
- clk_in  in  1  system clock, all logic on rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- fx2FifoSel_out  out  1  0 selects EP2 (host->FPGA), 1 selects EP6 (FPGA->host).
- fx2Data_in  in  8  FX2 data bus input.
- fx2Data_out  out  8  FX2 data bus output.
- fx2Data_sel  out  1  1 = FPGA drives the FX2 bus (tristate enable).
- fx2Read_out  out  1  SLRD, active-low.
- fx2GotData_in  in  1  EP2 not empty, active-high.
- fx2Write_out  out  1  SLWR, active-low.
- fx2GotRoom_in  in  1  EP6 not full, active-high.
- fx2PktEnd_out  out  1  PKTEND, active-low, one-cycle pulse.
- chanAddr_out  out  CHAN_WIDTH  channel of the current transfer.
- h2fData_out  out  8  host->FPGA data.
- h2fValid_out  out  1  h2f valid.
- h2fReady_in  in  1  h2f ready.
- f2hData_in  in  8  FPGA->host data.
- f2hValid_in  in  1  f2h valid.
- f2hReady_out  out  1  f2h ready.
- xferActive_out  out  1  1 from the command byte through the end of the transfer.
- xferDir_out  out  1  latched cmd[7]: 1 = read (f2h), 0 = write (h2f).

Behaviour:
- Handshakes: a byte moves when valid and ready are both high on the same edge, with zero latency.
  - Write data path: h2fData_out = fx2Data_in; h2fValid_out = fx2GotData_in; fx2Read_out = ~(fx2GotData_in & h2fReady_in).
  - Read data path: fx2Data_out = f2hData_in; f2hReady_out = fx2GotRoom_in; fx2Write_out = ~(f2hValid_in & fx2GotRoom_in).
  - These paths are live only in the data states. In every other state the strobes are inactive (1), the valid/ready outputs are 0 and fx2Data_sel = 0.
- Reset (async assert, sync deassert):
  - State IDLE; fx2FifoSel_out=0, fx2Data_sel=0; fx2Read_out, fx2Write_out, fx2PktEnd_out = 1.
  - h2fValid_out=0, f2hReady_out=0; chanAddr_out=0, xferActive_out=0, xferDir_out=0.
  - All counters 0.
  - Reset mid-transfer aborts the transfer immediately; no PKTEND is issued.
- States:
  - IDLE: FifoSel=0. Reads when fx2GotData_in (fx2Read_out=0), latches cmd → chanAddr_out, xferDir_out; xferActive_out goes to 1; → GET_LEN.
  - GET_LEN: reads LEN_BYTES bytes MSB first, one per cycle that fx2GotData_in=1, into a count of 8*LEN_BYTES bits. After the last byte:
    - count==0 → IDLE, xferActive_out drops.
    - dir=0 → H2F.
    - dir=1 → TURN.
  - H2F: one byte per handshake, count decrements; the final handshake → IDLE.
  - TURN: one cycle with FifoSel=1, no strobes (FX2 flag settle) → F2H.
  - F2H: fx2Data_sel=1. Each handshake decrements count and increments pktCnt, which wraps mod PKT_SIZE. On the final byte:
    - pktCnt after that byte != 0 → PKTEND.
    - Otherwise the full packet auto-commits → IDLE.
  - PKTEND: fx2PktEnd_out=0 for one cycle, FifoSel=1 → IDLE.
  - pktCnt clears on entry to TURN.
- Boundaries:
  - Length at maximum (all ones) is legal with no wrap.
  - fx2GotData_in low while in GET_LEN stalls the state.
  - fx2GotRoom_in low in F2H stalls the transfer; f2hReady_out stays 0.
  - xferActive_out is 1 in GET_LEN, H2F, TURN, F2H and PKTEND.

Decomposition:
- Package comm_fx2_pkg holds: state enum (IDLE, GET_LEN, H2F, TURN, F2H, PKTEND), CMD_DIR_BIT=7, FIFO_OUT=0, FIFO_IN=1, and the length-index width function.
- Sub-module fx2_xfer_counter holds:
  - the length load/shift and decrement;
  - pktCnt;
  - the last / short-packet flags.

Test Plan:
- Write, chan 5, length 3 (cmd 0x05, 00 00 00 03, data AA BB CC), h2fReady=1 → h2f sees AA, BB, CC with chanAddr_out=5; back in IDLE after the third byte; no PKTEND.
- Read, chan 0x12, length 5, f2h 01..05 → TURN for one cycle, then 5 SLWR pulses, then a PKTEND pulse one cycle after the last byte; fx2FifoSel_out returns to 0.
- Read, length 512 with PKT_SIZE=512 → 512 writes, no PKTEND. Length 513 → PKTEND after byte 513.
- Zero-length write and zero-length read → IDLE directly after the length bytes, no data strobes, no PKTEND.
- Backpressure: toggle h2fReady every cycle; drop fx2GotRoom for 10 cycles mid-read → no lost or duplicated bytes, counts exact.
- Assert reset_in=0 mid-read at byte 2 of 5 → outputs reach reset values asynchronously, no PKTEND; the next command parses correctly. Repeat with LEN_BYTES=2, CHAN_WIDTH=3.
